spart_tx: RTL and testbench



---
 rtl/spart_pkg.sv | 30 +++
 rtl/spart_tx_fifo.sv | 60 ++++++
 rtl/spart_tx.sv | 208 ++++++++++++++++++++
 tb/tb_spart_tx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART transmitter: register map,
// STATUS bit positions, shifter states and divisor limits.
package spart_pkg;

    localparam logic [1:0] ADDR_TXDATA = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int ST_BUSY  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_FULL  = 3;
    localparam int ST_OVF   = 4;
    localparam int ST_PAR   = 5;

    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_e;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/spart_tx_fifo.sv
// Synchronous transmit FIFO; a push while full is still taken
// when a pop frees a slot on the same edge.
module spart_tx_fifo
    import spart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spart_tx.sv
// Memory-mapped UART transmitter (8N1, optional even parity when
// SPART_TX_PARITY_EN is defined) with a CPU-writable FIFO.
module spart_tx
    import spart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       read,
    input  logic [1:0] addr,
    inout  wire [15:0] DataBus,
    output logic       txd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e   state;
    tx_state_e   next_state;
    logic [15:0] div_q;
    logic [15:0] cur_div;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        overflow;

    logic        wr_tx;
    logic        wr_div;
    logic        rd_stat;
    logic        pop;
    logic        load;
    logic        tick;
    logic        busy;
    logic        has_data;

    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    logic [15:0] status;
    logic [15:0] rdata;

`ifdef SPART_TX_PARITY_EN
    logic par_q;
`endif

    assign wr_tx   = cs & ~read & (addr == ADDR_TXDATA);
    assign wr_div  = cs & ~read & (addr == ADDR_DIV);
    assign rd_stat = cs & read & (addr == ADDR_STATUS);

    spart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_tx),
        .din   (DataBus[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign has_data = (fifo_count != '0);
    assign tick     = (baud_cnt == '0);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= DEFAULT_DIV;
        end else if (wr_div) begin
            div_q <= clamp_div(DataBus);
        end
    end

    // A dropped write sets the flag; a STATUS read clears it afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_tx & fifo_full & ~pop) begin
            overflow <= 1'b1;
        end else if (rd_stat) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        load       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (has_data) begin
                    next_state = S_START;
                    pop        = 1'b1;
                    load       = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (tick && bit_cnt == 3'd7) begin
`ifdef SPART_TX_PARITY_EN
                    next_state = S_PARITY;
`else
                    next_state = S_STOP;
`endif
                end
            end
`ifdef SPART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    next_state = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (has_data) begin
                        next_state = S_START;
                        pop        = 1'b1;
                        load       = 1'b1;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cur_div  <= DEFAULT_DIV;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                cur_div  <= div_q;
                baud_cnt <= div_q - 16'd1;
                bit_cnt  <= '0;
                shreg    <= fifo_dout;
            end else if (busy) begin
                baud_cnt <= tick ? (cur_div - 16'd1) : (baud_cnt - 16'd1);
                if (state == S_DATA && tick) begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

`ifdef SPART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= ^fifo_dout;
        end
    end
`endif

    always_comb begin
        txd = 1'b1;
        unique case (state)
            S_START:  txd = 1'b0;
            S_DATA:   txd = shreg[0];
`ifdef SPART_TX_PARITY_EN
            S_PARITY: txd = par_q;
`endif
            default:  txd = 1'b1;
        endcase
    end

    always_comb begin
        status           = '0;
        status[ST_BUSY]  = busy;
        status[ST_EMPTY] = fifo_empty;
        status[ST_FULL]  = fifo_full;
        status[ST_OVF]   = overflow;
`ifdef SPART_TX_PARITY_EN
        status[ST_PAR]   = 1'b1;
`endif
    end

    always_comb begin
        rdata = '0;
        unique case (addr)
            ADDR_STATUS: rdata = status;
            ADDR_DIV:    rdata = div_q;
            default:     rdata = '0;
        endcase
    end

    assign DataBus = (cs & read) ? rdata : 16'hzzzz;

endmodule

// File: tb/tb_spart_tx.sv
// Directed self-checking bench for spart_tx: reset, framing,
// back-to-back/full/overflow, divisor changes, reset mid-frame.
module tb_spart_tx;

`ifdef SPART_TX_PARITY_EN
    localparam bit          PAR  = 1'b1;
    localparam logic [15:0] CAP  = 16'h0020;
    localparam int          FLEN = 11;
`else
    localparam bit          PAR  = 1'b0;
    localparam logic [15:0] CAP  = 16'h0000;
    localparam int          FLEN = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic        read = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] bus_drv = 16'h0000;
    logic        bus_oe = 1'b0;
    wire  [15:0] DataBus;
    logic        txd;

    int n_cmp = 0;
    int n_err = 0;

    assign DataBus = bus_oe ? bus_drv : 16'hzzzz;

    spart_tx #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd868)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .read    (read),
        .addr    (addr),
        .DataBus (DataBus),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called away from the clock edge; returns #1 after the sampling edge.
    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cs = 1'b1; read = 1'b0; addr = a;
        bus_drv = d; bus_oe = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0; bus_oe = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] d);
        cs = 1'b1; read = 1'b1; addr = a; bus_oe = 1'b0;
        #1 d = DataBus;
        @(posedge clk); #1;
        cs = 1'b0; read = 1'b0;
    endtask

    // Call #1 after the edge that precedes the frame's first edge.
    task automatic check_frame(input logic [7:0] b, input int div,
                               input int nper);
        logic [10:0] seq;
        seq = '1;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[i+1] = b[i];
        if (PAR) seq[9] = ^b;
        for (int k = 0; k < nper; k++) begin
            for (int c = 0; c < div; c++) begin
                @(posedge clk); #1;
                check($sformatf("frame%02h_bit%0d_cyc%0d", b, k, c),
                      {15'd0, txd}, {15'd0, seq[k]});
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;

        // 1: reset and idle
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check("idle_txd", {15'd0, txd}, 16'h0001);
        end
        bus_drv = 16'hA5C3; bus_oe = 1'b1; read = 1'b1;
        #1 check("bus_hiz_cs0", DataBus, 16'hA5C3);
        bus_oe = 1'b0; read = 1'b0;
        rd(2'd1, v); check("rst_status", v, 16'h0004 | CAP);
        rd(2'd2, v); check("rst_div", v, 16'h0364);
        rd(2'd0, v); check("rd_txdata", v, 16'h0000);
        rd(2'd3, v); check("rd_rsvd", v, 16'h0000);
        wr(2'd2, 16'd4);
        rd(2'd2, v); check("div4", v, 16'h0004);

        // 2: single byte
        wr(2'd0, 16'hAB55);
        check_frame(8'h55, 4, FLEN);
        @(posedge clk); #1;
        rd(2'd1, v); check("single_done_status", v, 16'h0004 | CAP);

        // 4: divisor change mid-frame
        wr(2'd0, 16'h003C);
        fork
            begin
                check_frame(8'h3C, 4, FLEN);
                check_frame(8'hC5, 8, FLEN);
            end
            begin
                wr(2'd0, 16'h00C5);
                wr(2'd2, 16'd8);
            end
        join
        @(posedge clk); #1;
        wr(2'd2, 16'd1);
        rd(2'd2, v); check("div_clamp1", v, 16'h0002);
        wr(2'd2, 16'd0);
        rd(2'd2, v); check("div_clamp0", v, 16'h0002);
        wr(2'd2, 16'd4);

        // 3: back-to-back, full, overflow, push+pop while full
        wr(2'd0, 16'h00A3);
        fork
            begin
                check_frame(8'hA3, 4, FLEN);
                check_frame(8'h0F, 4, FLEN);
                check_frame(8'hFF, 4, FLEN);
            end
            begin
                wr(2'd0, 16'h000F);
                wr(2'd0, 16'h00FF);
                for (int i = 0; i < 9; i++) wr(2'd0, 16'h0010 + 16'(i));
                rd(2'd1, v); check("full_ovf_status1", v, 16'h001A | CAP);
                rd(2'd1, v); check("full_ovf_status2", v, 16'h000A | CAP);
                repeat (FLEN*4 - 13) @(posedge clk);
                #1 wr(2'd0, 16'h0020);
                rd(2'd1, v); check("push_pop_full", v, 16'h000A | CAP);
            end
        join

        // 5: reset mid-frame with bytes queued
        check_frame(8'h10, 4, 4);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_txd", {15'd0, txd}, 16'h0001);
        rst = 1'b0;
        rd(2'd1, v); check("rst_mid_status", v, 16'h0004 | CAP);
        rd(2'd2, v); check("rst_mid_div", v, 16'h0364);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            check("post_rst_txd", {15'd0, txd}, 16'h0001);
        end

`ifdef SPART_TX_PARITY_EN
        // 6: parity bit and 44-cycle frame
        wr(2'd2, 16'd4);
        wr(2'd0, 16'h0007);
        check_frame(8'h07, 4, 9);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("par07_bit", {15'd0, txd}, 16'h0001);
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("par07_stop", {15'd0, txd}, 16'h0001);
        end
        @(posedge clk); #1;
        rd(2'd1, v); check("par_status", v, 16'h0024);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
